// File: rtl/kg_prog_loader.sv
// Program loader: edge-detects register-file writes, buffers {address, data} entries in a FIFO,
// drains them into core memory and holds the core in reset until software requests run.
module kg_prog_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_address_valid,
    input  logic [DATA_WIDTH-1:0]         cfg_address,
    input  logic                          cfg_data_valid,
    input  logic [DATA_WIDTH-1:0]         cfg_data,
    input  logic                          cfg_run,
    input  logic                          overflow_clear,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    input  logic                          mem_wr_ready,
    output logic                          core_rst,
    output logic                          busy,
    output logic                          overflow,
    output logic [15:0]                   write_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StHalt, StWrite, StRun} state_e;

    state_e                  state_q, state_d;
    logic                    addr_vld_prev_q, addr_vld_prev_d;
    logic                    data_vld_prev_q, data_vld_prev_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_idx_q, wr_idx_d;
    logic [PtrW-1:0]         rd_idx_q, rd_idx_d;
    logic [PtrW:0]           level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic [15:0]             write_count_q, write_count_d;

    logic                    addr_edge, data_edge, fifo_full, push, drop, pop;
    logic [ADDR_WIDTH-1:0]   new_addr, entry_addr;

    if (DATA_WIDTH > ADDR_WIDTH) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^cfg_address[DATA_WIDTH-1:ADDR_WIDTH];
    end

    // Full uses start-of-cycle occupancy, so a same-cycle pop never makes room for a push.
    always_comb begin
        new_addr   = cfg_address[ADDR_WIDTH-1:0];
        addr_edge  = cfg_address_valid & ~addr_vld_prev_q;
        data_edge  = cfg_data_valid & ~data_vld_prev_q;
        fifo_full  = (level_q == FullLevel);
        push       = data_edge & ~fifo_full & (state_q != StRun);
        drop       = data_edge & ~push;
        pop        = (state_q == StWrite) & mem_wr_ready;
        entry_addr = addr_edge ? new_addr : ptr_q;
    end

    always_comb begin
        addr_vld_prev_d = cfg_address_valid;
        data_vld_prev_d = cfg_data_valid;
        ptr_d           = ptr_q;
        fifo_addr_d     = fifo_addr_q;
        fifo_data_d     = fifo_data_q;
        wr_idx_d        = wr_idx_q;
        rd_idx_d        = rd_idx_q;
        level_d         = level_q;
        overflow_d      = overflow_q;
        write_count_d   = write_count_q;

        if (addr_edge) begin
            ptr_d = new_addr;
        end
        if (push) begin
            fifo_addr_d[wr_idx_q] = entry_addr;
            fifo_data_d[wr_idx_q] = cfg_data;
            wr_idx_d              = wr_idx_q + 1'b1;
            ptr_d                 = entry_addr + 1'b1;
        end
        if (pop) begin
            rd_idx_d      = rd_idx_q + 1'b1;
            write_count_d = write_count_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (level_q != '0) begin
                    state_d = StWrite;
                end else if (cfg_run) begin
                    state_d = StRun;
                end
            end
            StWrite: begin
                if (pop && (level_d == '0)) begin
                    state_d = StHalt;
                end
            end
            StRun: begin
                if (!cfg_run) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        mem_wr_en   = (state_q == StWrite);
        mem_wr_addr = mem_wr_en ? fifo_addr_q[rd_idx_q] : '0;
        mem_wr_data = mem_wr_en ? fifo_data_q[rd_idx_q] : '0;
        core_rst    = (state_q != StRun);
        busy        = (state_q == StWrite) | (level_q != '0);
        overflow    = overflow_q;
        write_count = write_count_q;
        fifo_level  = level_q;
    end

    // Edge-detect history follows the inputs even in reset, so levels held across reset are ignored.
    always_ff @(posedge clk) begin
        addr_vld_prev_q <= addr_vld_prev_d;
        data_vld_prev_q <= data_vld_prev_d;
        if (rst) begin
            state_q       <= StHalt;
            ptr_q         <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            write_count_q <= write_count_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_kg_prog_loader.sv
// Directed self-checking bench for kg_prog_loader: one task per scenario, expectations hand-computed.
module tb_kg_prog_loader;

    logic        clk;
    logic        rst;
    logic        cfg_address_valid;
    logic [31:0] cfg_address;
    logic        cfg_data_valid;
    logic [31:0] cfg_data;
    logic        cfg_run;
    logic        overflow_clear;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        core_rst;
    logic        busy;
    logic        overflow;
    logic [15:0] write_count;
    logic [3:0]  fifo_level;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] cap_addr[$];
    logic [31:0] cap_data[$];

    kg_prog_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .FIFO_DEPTH(8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_address_valid (cfg_address_valid),
        .cfg_address       (cfg_address),
        .cfg_data_valid    (cfg_data_valid),
        .cfg_data          (cfg_data),
        .cfg_run           (cfg_run),
        .overflow_clear    (overflow_clear),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_ready      (mem_wr_ready),
        .core_rst          (core_rst),
        .busy              (busy),
        .overflow          (overflow),
        .write_count       (write_count),
        .fifo_level        (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 1 time unit after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_wr_ready) begin
            cap_addr.push_back(mem_wr_addr);
            cap_data.push_back(mem_wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic [31:0] a);
        cfg_address = a;
        cfg_address_valid = 1'b1;
        tick();
        cfg_address_valid = 1'b0;
        tick();
    endtask

    task automatic send_data(input logic [31:0] d);
        cfg_data = d;
        cfg_data_valid = 1'b1;
        tick();
        cfg_data_valid = 1'b0;
        tick();
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tests_run++; if (mem_wr_en !== 1'b0) begin tests_failed++;
            $display("FAIL reset_en got %b want 0", mem_wr_en); end
        tests_run++; if (mem_wr_addr !== 16'h0) begin tests_failed++;
            $display("FAIL reset_addr got %h want 0000", mem_wr_addr); end
        tests_run++; if (mem_wr_data !== 32'h0) begin tests_failed++;
            $display("FAIL reset_data got %h want 0", mem_wr_data); end
        tests_run++; if (core_rst !== 1'b1) begin tests_failed++;
            $display("FAIL reset_core_rst got %b want 1", core_rst); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL reset_overflow got %b want 0", overflow); end
        tests_run++; if (write_count !== 16'h0) begin tests_failed++;
            $display("FAIL reset_write_count got %h want 0", write_count); end
        tests_run++; if (fifo_level !== 4'd0) begin tests_failed++;
            $display("FAIL reset_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_basic();
        bit ok;
        cap_addr.delete(); cap_data.delete();
        mem_wr_ready = 1'b1;
        send_addr(32'h0010);
        cfg_data = 32'hA;
        cfg_data_valid = 1'b1;
        tick();
        tests_run++; if (mem_wr_en !== 1'b0 || fifo_level !== 4'd1) begin tests_failed++;
            $display("FAIL basic_edge1 got en=%b level=%0d want en=0 level=1", mem_wr_en, fifo_level); end
        cfg_data_valid = 1'b0;
        tick();
        tests_run++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'h0010 || mem_wr_data !== 32'hA) begin
            tests_failed++;
            $display("FAIL basic_edge2 got en=%b addr=%h data=%h want en=1 addr=0010 data=a",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        tick();
        send_data(32'hB);
        send_data(32'hC);
        wait_idle(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_idle got busy=1 want 0"); end
        tests_run++;
        if (cap_addr.size() != 3 || cap_addr[0] !== 16'h10 || cap_addr[1] !== 16'h11 ||
            cap_addr[2] !== 16'h12 || cap_data[0] !== 32'hA || cap_data[1] !== 32'hB ||
            cap_data[2] !== 32'hC) begin
            tests_failed++;
            $display("FAIL basic_writes got n=%0d a=%p d=%p want 10/11/12 a/b/c",
                     cap_addr.size(), cap_addr, cap_data);
        end
        tests_run++; if (write_count !== 16'd3) begin tests_failed++;
            $display("FAIL basic_count got %0d want 3", write_count); end
    endtask

    task automatic test_wrap();
        bit ok;
        cap_addr.delete(); cap_data.delete();
        send_addr(32'hFFFF);
        send_data(32'h1111);
        send_data(32'h2222);
        wait_idle(ok);
        tests_run++;
        if (!ok || cap_addr.size() != 2 || cap_addr[0] !== 16'hFFFF || cap_addr[1] !== 16'h0000 ||
            cap_data[0] !== 32'h1111 || cap_data[1] !== 32'h2222) begin
            tests_failed++;
            $display("FAIL wrap_writes got n=%0d a=%p d=%p want ffff/0000 1111/2222",
                     cap_addr.size(), cap_addr, cap_data);
        end
    endtask

    task automatic test_overflow();
        cap_addr.delete(); cap_data.delete();
        mem_wr_ready = 1'b0;
        send_addr(32'h0100);
        for (int i = 0; i < 9; i++) send_data(32'h1000 + i);
        tests_run++; if (fifo_level !== 4'd8) begin tests_failed++;
            $display("FAIL ovf_level got %0d want 8", fifo_level); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++;
            $display("FAIL ovf_flag got %b want 1", overflow); end
        tests_run++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 16'h0100 || mem_wr_data !== 32'h1000) begin
            tests_failed++;
            $display("FAIL ovf_hold got en=%b addr=%h data=%h want 1/0100/1000",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        mem_wr_ready = 1'b1;
        repeat (7) tick();
        tests_run++; if (busy !== 1'b1 || fifo_level !== 4'd1) begin tests_failed++;
            $display("FAIL ovf_b2b7 got busy=%b level=%0d want 1/1", busy, fifo_level); end
        tick();
        tests_run++; if (busy !== 1'b0 || write_count !== 16'd13) begin tests_failed++;
            $display("FAIL ovf_b2b8 got busy=%b count=%0d want 0/13", busy, write_count); end
        tests_run++;
        if (cap_addr.size() != 8 || cap_addr[7] !== 16'h0107 || cap_data[7] !== 32'h1007) begin
            tests_failed++;
            $display("FAIL ovf_writes got n=%0d a=%p d=%p want 8 ending 0107/1007",
                     cap_addr.size(), cap_addr, cap_data);
        end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++;
            $display("FAIL ovf_sticky got %b want 1", overflow); end
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        cap_addr.delete(); cap_data.delete();
        cfg_address = 32'h0040;
        cfg_data = 32'h55;
        cfg_address_valid = 1'b1;
        cfg_data_valid = 1'b1;
        tick();
        cfg_address_valid = 1'b0;
        cfg_data_valid = 1'b0;
        tick();
        send_data(32'h66);
        wait_idle(ok);
        tests_run++;
        if (!ok || cap_addr.size() != 2 || cap_addr[0] !== 16'h0040 || cap_data[0] !== 32'h55 ||
            cap_addr[1] !== 16'h0041 || cap_data[1] !== 32'h66) begin
            tests_failed++;
            $display("FAIL same_cycle got n=%0d a=%p d=%p want 0040/55 0041/66",
                     cap_addr.size(), cap_addr, cap_data);
        end
    endtask

    task automatic test_run();
        bit ok;
        cap_addr.delete(); cap_data.delete();
        mem_wr_ready = 1'b0;
        send_addr(32'h0200);
        send_data(32'hD0);
        send_data(32'hD1);
        cfg_run = 1'b1;
        repeat (3) tick();
        tests_run++; if (core_rst !== 1'b1 || mem_wr_addr !== 16'h0200) begin tests_failed++;
            $display("FAIL run_hold got core_rst=%b addr=%h want 1/0200", core_rst, mem_wr_addr); end
        mem_wr_ready = 1'b1;
        wait_idle(ok);
        tests_run++; if (!ok || core_rst !== 1'b1) begin tests_failed++;
            $display("FAIL run_drained got busy=%b core_rst=%b want 0/1", busy, core_rst); end
        tick();
        tests_run++; if (core_rst !== 1'b0) begin tests_failed++;
            $display("FAIL run_release got %b want 0", core_rst); end
        tests_run++;
        if (cap_addr.size() != 2 || cap_addr[1] !== 16'h0201 || cap_data[1] !== 32'hD1) begin
            tests_failed++;
            $display("FAIL run_writes got n=%0d a=%p d=%p want 2 ending 0201/d1",
                     cap_addr.size(), cap_addr, cap_data);
        end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL run_pre_ovf got %b want 0", overflow); end
        send_data(32'hEE);
        tests_run++; if (overflow !== 1'b1 || fifo_level !== 4'd0 || core_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_drop got ovf=%b level=%0d core_rst=%b want 1/0/0",
                     overflow, fifo_level, core_rst);
        end
        cfg_run = 1'b0;
        tick();
        tests_run++; if (core_rst !== 1'b1 || write_count !== 16'd17) begin tests_failed++;
            $display("FAIL run_exit got core_rst=%b count=%0d want 1/17", core_rst, write_count); end
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        mem_wr_ready = 1'b0;
        send_addr(32'h0300);
        send_data(32'h31);
        send_data(32'h32);
        send_data(32'h33);
        tests_run++; if (fifo_level !== 4'd3 || mem_wr_en !== 1'b1) begin tests_failed++;
            $display("FAIL rstw_pre got level=%0d en=%b want 3/1", fifo_level, mem_wr_en); end
        cfg_data = 32'h99;
        cfg_data_valid = 1'b1;
        rst = 1'b1;
        tick();
        tests_run++;
        if (mem_wr_en !== 1'b0 || fifo_level !== 4'd0 || core_rst !== 1'b1 ||
            write_count !== 16'd0 || mem_wr_addr !== 16'h0) begin
            tests_failed++;
            $display("FAIL rstw_reset got en=%b level=%0d core_rst=%b count=%0d addr=%h want 0/0/1/0/0",
                     mem_wr_en, fifo_level, core_rst, write_count, mem_wr_addr);
        end
        tick();
        rst = 1'b0;
        cap_addr.delete(); cap_data.delete();
        mem_wr_ready = 1'b1;
        repeat (4) tick();
        tests_run++; if (fifo_level !== 4'd0 || busy !== 1'b0 || cap_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL rstw_held got level=%0d busy=%b writes=%0d want 0/0/0",
                     fifo_level, busy, cap_addr.size());
        end
        cfg_data_valid = 1'b0;
        tick();
        send_data(32'h77);
        wait_idle(ok);
        tests_run++;
        if (!ok || cap_addr.size() != 1 || cap_addr[0] !== 16'h0000 || cap_data[0] !== 32'h77 ||
            write_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL rstw_after got n=%0d a=%p d=%p count=%0d want 1 write 0000/77 count=1",
                     cap_addr.size(), cap_addr, cap_data, write_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_address_valid = 1'b0;
        cfg_address = '0;
        cfg_data_valid = 1'b0;
        cfg_data = '0;
        cfg_run = 1'b0;
        overflow_clear = 1'b0;
        mem_wr_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_same_cycle();
        test_run();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
